// File: rtl/ddram_readback_checker.sv
// Burst-reads a DDR3 word range over DDRAM and compares every beat against the fill value.
// Define DDRAM_CHECK_PATTERN_EN to expect an address-pattern fill instead of the constant EXPECT.
module ddram_readback_checker #(
  parameter logic [28:0] BASE_ADDR = 29'h0,
  parameter logic [28:0] NUM_WORDS = 29'h100000,
  parameter int          BURST     = 128,
  parameter logic [63:0] EXPECT    = 64'h0,
  parameter int          TIMEOUT   = 4096
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        start,
  input  logic        DDRAM_BUSY,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY,
  output logic        DDRAM_RD,
  output logic [28:0] DDRAM_ADDR,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic        DDRAM_WE,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_cnt,
  output logic [28:0] first_err_addr,
  output logic [28:0] words_done,
  output logic [1:0]  dbg_state
);

  localparam int          TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT - 1);
  localparam logic [7:0]  BURST8  = 8'(BURST);
  localparam logic [28:0] BURST29 = 29'(BURST);

  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

  state_t        state, state_next;
  logic [28:0]   cur_addr;
  logic [28:0]   remaining;
  logic [7:0]    beats_left;
  logic [7:0]    beat_idx;
  logic [TW-1:0] tcnt;

  logic [28:0] beat_addr;
  logic [63:0] expected;
  logic        accept;
  logic        beat;
  logic        last_beat;
  logic        tmo_hit;
  logic [7:0]  next_len;
  logic [28:0] remaining_after;

  assign DDRAM_WE  = 1'b0;
  assign DDRAM_DIN = 64'h0;
  assign DDRAM_BE  = 8'hFF;

  assign busy      = (state == REQ) || (state == DATA);
  assign done      = (state == DONE);
  assign pass      = done && (err_cnt == 16'h0) && !timeout;
  assign dbg_state = state;

  // Handshake: a request is taken on any edge with DDRAM_RD=1 and DDRAM_BUSY=0
  // (RD/ADDR/BURSTCNT are held until then); each edge with DDRAM_DOUT_READY=1 carries one beat.
  assign beat_addr = cur_addr + {21'd0, beat_idx};
`ifdef DDRAM_CHECK_PATTERN_EN
  assign expected = {3'b000, ~beat_addr, 3'b000, beat_addr};
`else
  assign expected = EXPECT;
`endif

  assign accept          = (state == REQ) && DDRAM_RD && !DDRAM_BUSY;
  assign beat            = (state == DATA) && DDRAM_DOUT_READY;
  assign last_beat       = beat && (beats_left == 8'd1);
  assign tmo_hit         = ((state == REQ) || (state == DATA)) && (tcnt == TMAX) && !accept && !beat;
  assign next_len        = (remaining < BURST29) ? remaining[7:0] : BURST8;
  assign remaining_after = remaining - {21'd0, DDRAM_BURSTCNT};

  always_ff @(posedge clk_sys) begin
    if (!RESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = REQ;
      REQ: begin
        if (tmo_hit)     state_next = DONE;
        else if (accept) state_next = DATA;
      end
      DATA: begin
        if (last_beat)    state_next = (remaining_after == 29'd0) ? DONE : REQ;
        else if (tmo_hit) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!RESET) begin
      DDRAM_RD       <= 1'b0;
      DDRAM_ADDR     <= 29'd0;
      DDRAM_BURSTCNT <= 8'd0;
      timeout        <= 1'b0;
      err_cnt        <= 16'd0;
      first_err_addr <= 29'd0;
      words_done     <= 29'd0;
      cur_addr       <= 29'd0;
      remaining      <= 29'd0;
      beats_left     <= 8'd0;
      beat_idx       <= 8'd0;
      tcnt           <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            timeout        <= 1'b0;
            err_cnt        <= 16'd0;
            first_err_addr <= 29'd0;
            words_done     <= 29'd0;
            cur_addr       <= BASE_ADDR;
            remaining      <= NUM_WORDS;
            tcnt           <= '0;
          end
        end
        REQ: begin
          if (tmo_hit) begin
            DDRAM_RD <= 1'b0;
            timeout  <= 1'b1;
          end else if (accept) begin
            DDRAM_RD   <= 1'b0;
            beats_left <= DDRAM_BURSTCNT;
            beat_idx   <= 8'd0;
            tcnt       <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
            // First REQ cycle is the inter-burst gap; the request is raised one cycle later.
            if (!DDRAM_RD) begin
              DDRAM_RD       <= 1'b1;
              DDRAM_ADDR     <= cur_addr;
              DDRAM_BURSTCNT <= next_len;
            end
          end
        end
        DATA: begin
          if (beat) begin
            words_done <= words_done + 29'd1;
            beat_idx   <= beat_idx + 8'd1;
            beats_left <= beats_left - 8'd1;
            tcnt       <= '0;
            if (DDRAM_DOUT != expected) begin
              if (err_cnt == 16'd0)    first_err_addr <= beat_addr;
              if (err_cnt != 16'hFFFF) err_cnt        <= err_cnt + 16'd1;
            end
            if (last_beat) begin
              cur_addr  <= cur_addr + {21'd0, DDRAM_BURSTCNT};
              remaining <= remaining_after;
            end
          end else if (tmo_hit) begin
            timeout <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddram_readback_checker.sv
// Randomized bench for ddram_readback_checker: DDRAM slave model, request/result scoreboard.
module tb_ddram_readback_checker;

  localparam logic [28:0] P_BASE   = 29'h1FFFFF80;
  localparam logic [28:0] P_NUM    = 29'd300;
  localparam int          P_BURST  = 128;
  localparam logic [63:0] P_EXPECT = 64'h0123_4567_89AB_CDEF;
  localparam int          P_TMO    = 64;

  typedef struct packed {
    logic        pass;
    logic        tmo;
    logic [15:0] err;
    logic [28:0] first;
    logic [28:0] words;
  } res_t;

  logic        clk_sys, RESET, start, DDRAM_BUSY, DDRAM_DOUT_READY;
  logic [63:0] DDRAM_DOUT;
  logic        DDRAM_RD, DDRAM_WE;
  logic [28:0] DDRAM_ADDR;
  logic [7:0]  DDRAM_BURSTCNT, DDRAM_BE;
  logic [63:0] DDRAM_DIN;
  logic        busy, done, pass, timeout;
  logic [15:0] err_cnt;
  logic [28:0] first_err_addr, words_done;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [36:0] exp_req_q[$];
  res_t        exp_res_q[$];
  logic [63:0] corrupt[logic [28:0]];
  logic [28:0] beat_q[$];
  bit          no_data   = 0;
  int          busy_pct  = 0;
  int          hold_busy = 0;
  int          acc_cnt   = 0;

  ddram_readback_checker #(
    .BASE_ADDR(P_BASE), .NUM_WORDS(P_NUM), .BURST(P_BURST), .EXPECT(P_EXPECT), .TIMEOUT(P_TMO)
  ) dut (
    .clk_sys(clk_sys), .RESET(RESET), .start(start),
    .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
    .DDRAM_RD(DDRAM_RD), .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_BURSTCNT(DDRAM_BURSTCNT),
    .DDRAM_WE(DDRAM_WE), .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr), .words_done(words_done),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  function automatic logic [63:0] fill_word(input logic [28:0] a);
`ifdef DDRAM_CHECK_PATTERN_EN
    return {3'b000, ~a, 3'b000, a};
`else
    if (a == 29'd0) return P_EXPECT;
    return P_EXPECT;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: split the range into bursts of at most BURST and tally corrupted words in order.
  task automatic model_push(input bit with_res);
    logic [28:0] a     = P_BASE;
    logic [28:0] rem   = P_NUM;
    logic [28:0] first = 29'd0;
    logic [7:0]  n;
    int          cnt   = 0;
    res_t        r;
    while (rem != 29'd0) begin
      n = (rem < 29'(P_BURST)) ? rem[7:0] : 8'(P_BURST);
      exp_req_q.push_back({a, n});
      a   = a + 29'(n);
      rem = rem - 29'(n);
    end
    for (int i = 0; i < int'(P_NUM); i++) begin
      logic [28:0] wa;
      wa = P_BASE + 29'(i);
      if (corrupt.exists(wa)) begin
        if (cnt == 0) first = wa;
        cnt++;
      end
    end
    r.pass  = (cnt == 0);
    r.tmo   = 1'b0;
    r.err   = (cnt > 65535) ? 16'hFFFF : 16'(cnt);
    r.first = first;
    r.words = P_NUM;
    if (with_res) exp_res_q.push_back(r);
  endtask

  task automatic push_timeout_result();
    res_t r;
    r.pass = 1'b0; r.tmo = 1'b1; r.err = 16'd0; r.first = 29'd0; r.words = 29'd0;
    exp_res_q.push_back(r);
  endtask

  task automatic pulse_start();
    @(negedge clk_sys); start = 1'b1;
    @(negedge clk_sys); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit poke);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk_sys);
      start = poke && (n == 40);
      #4;
      n++;
    end
    start = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL wait_done: done=%0b after %0d cycles, expected 1", done, budget);
    end
  endtask

  task automatic corrupt_random();
    int nerr;
    logic [28:0] a;
    corrupt.delete();
    nerr = $urandom_range(0, 4);
    for (int i = 0; i < nerr; i++) begin
      a = P_BASE + 29'($urandom_range(0, int'(P_NUM) - 1));
      corrupt[a] = fill_word(a) ^ (64'h1 << $urandom_range(0, 63));
    end
  endtask

  // DDRAM slave: drives at negedge, records a request once RD/BUSY are settled for the next edge.
  initial begin
    logic [28:0] a;
    DDRAM_BUSY = 1'b0; DDRAM_DOUT_READY = 1'b0; DDRAM_DOUT = 64'h0;
    forever begin
      @(negedge clk_sys);
      if (beat_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        a = beat_q.pop_front();
        DDRAM_DOUT       = corrupt.exists(a) ? corrupt[a] : fill_word(a);
        DDRAM_DOUT_READY = 1'b1;
      end else begin
        DDRAM_DOUT       = {$urandom(), $urandom()};
        DDRAM_DOUT_READY = 1'b0;
      end
      if (hold_busy > 0 && DDRAM_RD) begin
        DDRAM_BUSY = 1'b1;
        hold_busy--;
      end else begin
        DDRAM_BUSY = ($urandom_range(0, 99) < busy_pct);
      end
      #1;
      if (DDRAM_RD && !DDRAM_BUSY && RESET) begin
        acc_cnt++;
        if (!no_data)
          for (int k = 0; k < int'(DDRAM_BURSTCNT); k++) beat_q.push_back(DDRAM_ADDR + 29'(k));
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic        held = 1'b0;
    logic        done_prev = 1'b0;
    logic [28:0] h_addr;
    logic [7:0]  h_cnt;
    logic [36:0] e;
    res_t        r;
    forever begin
      @(negedge clk_sys);
      #3;
      if (!RESET) begin
        held = 1'b0;
        done_prev = 1'b0;
      end else begin
        if (held && !timeout) begin
          check("hold_rd", DDRAM_RD, 1'b1);
          check("hold_addr", DDRAM_ADDR, h_addr);
          check("hold_cnt", DDRAM_BURSTCNT, h_cnt);
        end
        if (DDRAM_RD && !DDRAM_BUSY) begin
          if (exp_req_q.size() == 0) begin
            total++; bad++;
            $display("FAIL req_unexpected: addr %0h cnt %0d, expected no request", DDRAM_ADDR, DDRAM_BURSTCNT);
          end else begin
            e = exp_req_q.pop_front();
            check("req_addr", DDRAM_ADDR, e[36:8]);
            check("req_cnt", DDRAM_BURSTCNT, e[7:0]);
          end
        end
        held   = DDRAM_RD && DDRAM_BUSY;
        h_addr = DDRAM_ADDR;
        h_cnt  = DDRAM_BURSTCNT;
        if (done && !done_prev) begin
          if (exp_res_q.size() == 0) begin
            total++; bad++;
            $display("FAIL done_unexpected: done=1, expected no completion");
          end else begin
            r = exp_res_q.pop_front();
            check("res_pass", pass, r.pass);
            check("res_timeout", timeout, r.tmo);
            check("res_err_cnt", err_cnt, r.err);
            check("res_first_err", first_err_addr, r.first);
            check("res_words", words_done, r.words);
            check("res_busy", busy, 1'b0);
            check("res_rd", DDRAM_RD, 1'b0);
          end
        end
        done_prev = done;
      end
    end
  end

  // Stimulus
  initial begin
    int old, n;
    RESET = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk_sys);
    #3;
    check("rst_rd", DDRAM_RD, 1'b0);
    check("rst_addr", DDRAM_ADDR, 29'd0);
    check("rst_cnt", DDRAM_BURSTCNT, 8'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_err", err_cnt, 16'd0);
    check("rst_first", first_err_addr, 29'd0);
    check("rst_words", words_done, 29'd0);
    check("rst_state", dbg_state, 2'd0);
    check("const_we", DDRAM_WE, 1'b0);
    check("const_din", DDRAM_DIN, 64'h0);
    check("const_be", DDRAM_BE, 8'hFF);
    @(negedge clk_sys); RESET = 1'b1;

    // clean sweep across the 29-bit wrap, with random stalls
    corrupt.delete(); busy_pct = 20;
    model_push(1); pulse_start(); wait_done(3000, 0);

    // two single-bit errors
    corrupt[29'd100] = fill_word(29'd100) ^ 64'h1;
    corrupt[29'd110] = fill_word(29'd110) ^ 64'h8000_0000_0000_0000;
    model_push(1); pulse_start(); wait_done(3000, 0);

    // slave stalls the first request for 10 cycles
    corrupt.delete(); busy_pct = 0; hold_busy = 10;
    model_push(1); pulse_start(); wait_done(3000, 0);
    hold_busy = 0;

    // request accepted but no data ever returns
    no_data = 1'b1;
    exp_req_q.push_back({P_BASE, 8'(P_BURST)});
    push_timeout_result();
    old = acc_cnt;
    pulse_start();
    n = 0;
    while (acc_cnt == old && n < 300) begin
      @(negedge clk_sys); #2; n++;
    end
    total++;
    if (acc_cnt == old) begin
      bad++;
      $display("FAIL tmo_accept: no request accepted within 300 cycles, expected one");
    end else begin
      @(posedge clk_sys);
      for (int k = 1; k <= P_TMO; k++) begin
        @(posedge clk_sys); #1;
        if (k == P_TMO - 1) check("tmo_early", timeout, 1'b0);
      end
      check("tmo_flag", timeout, 1'b1);
      check("tmo_done", done, 1'b1);
      check("tmo_pass", pass, 1'b0);
      check("tmo_rd", DDRAM_RD, 1'b0);
    end
    no_data = 1'b0;
    repeat (2) @(negedge clk_sys);

    // request never accepted: timeout while still in REQ
    hold_busy = 1000;
    push_timeout_result();
    pulse_start(); wait_done(500, 0);
    hold_busy = 0;

    // reset in the middle of the first burst, then stray (corrupted) beats
    for (int i = 0; i < P_BURST; i++) corrupt[P_BASE + 29'(i)] = fill_word(P_BASE + 29'(i)) ^ 64'hFF;
    model_push(0); pulse_start();
    n = 0;
    while (words_done < 29'd8 && n < 1000) begin
      @(negedge clk_sys); #4; n++;
    end
    check("mid_reached", words_done >= 29'd8, 1'b1);
    @(negedge clk_sys); RESET = 1'b0;
    @(negedge clk_sys); RESET = 1'b1;
    #3;
    check("mrst_rd", DDRAM_RD, 1'b0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_done", done, 1'b0);
    check("mrst_err", err_cnt, 16'd0);
    check("mrst_words", words_done, 29'd0);
    exp_req_q.delete();
    n = 0;
    while (beat_q.size() > 0 && n < 2000) begin
      @(negedge clk_sys); n++;
    end
    repeat (4) @(negedge clk_sys);
    #3;
    check("stray_words", words_done, 29'd0);
    check("stray_err", err_cnt, 16'd0);
    check("stray_busy", busy, 1'b0);
    check("stray_done", done, 1'b0);

    // fresh start after reset
    corrupt.delete(); busy_pct = 10;
    model_push(1); pulse_start(); wait_done(3000, 0);

    // random corruption and stall mixes, with a start pulse while busy
    for (int t = 0; t < 5; t++) begin
      corrupt_random();
      busy_pct = $urandom_range(0, 40);
      model_push(1); pulse_start(); wait_done(3000, 1);
    end

    repeat (3) @(negedge clk_sys);
    check("req_q_left", exp_req_q.size(), 0);
    check("res_q_left", exp_res_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
